// File: rtl/vend_pkg.sv
// Shared encodings for the vending transaction controller: states, key codes,
// product prices and coin denominations.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_PRICE   = 3'd2,
        ST_QTY     = 3'd3,
        ST_CONFIRM = 3'd4,
        ST_PAY     = 3'd5,
        ST_CHANGE  = 3'd6,
        ST_VEND    = 3'd7
    } state_e;

    localparam logic [3:0] KEY_OK     = 4'hE;
    localparam logic [3:0] KEY_NEXT   = 4'hF;
    localparam logic [3:0] KEY_CANCEL = 4'hC;
    localparam logic [3:0] KEY_COIN1  = 4'h8;
    localparam logic [3:0] KEY_COIN5  = 4'h9;
    localparam logic [3:0] KEY_COIN10 = 4'hA;

    localparam logic [3:0] PRICE_P1 = 4'd6;
    localparam logic [3:0] PRICE_P2 = 4'd10;
    localparam logic [3:0] PRICE_P3 = 4'd5;
    localparam logic [3:0] PRICE_P4 = 4'd2;
    localparam logic [3:0] PRICE_P5 = 4'd1;

    localparam logic [3:0] COIN_1  = 4'd1;
    localparam logic [3:0] COIN_5  = 4'd5;
    localparam logic [3:0] COIN_10 = 4'd10;

    // Zero means "not a product key".
    function automatic logic [3:0] product_price(input logic [3:0] key);
        case (key)
            4'd1:    return PRICE_P1;
            4'd2:    return PRICE_P2;
            4'd3:    return PRICE_P3;
            4'd4:    return PRICE_P4;
            4'd5:    return PRICE_P5;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] greedy_coin(input logic [7:0] amount);
        if (amount >= 8'(COIN_10)) return COIN_10;
        if (amount >= 8'(COIN_5))  return COIN_5;
        return COIN_1;
    endfunction

endpackage

// File: rtl/vend_txn_controller_change_dispenser.sv
// Greedy change dispenser: loads an amount and pays it out as 10/5/1 coins
// over a valid/ready handshake; done is high once nothing is owed.
module change_dispenser
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] amount,
    input  logic       coin_ready,
    output logic       coin_valid,
    output logic [3:0] coin_value,
    output logic       done,
    output logic [7:0] change
);

    logic [7:0] change_q, change_d;

    // coin_value is a pure function of change_q, so it cannot move while stalled.
    always_comb begin
        change_d   = change_q;
        coin_valid = (change_q != 8'd0);
        coin_value = coin_valid ? greedy_coin(change_q) : 4'd0;
        if (load) begin
            change_d = amount;
        end else if (coin_valid && coin_ready) begin
            change_d = change_q - {4'b0, coin_value};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            change_q <= 8'd0;
        end else begin
            change_q <= change_d;
        end
    end

    assign done   = (change_q == 8'd0);
    assign change = change_q;

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer. Optional inactivity cancel: VEND_TIMEOUT_EN.
// Operator note: a reset mid-transaction discards credit and pending change.
//
// state   | meaning
// IDLE    | waiting for NEXT to start a transaction
// SELECT  | waiting for a product key 1..5
// PRICE   | showing unit price, OK to continue, CANCEL to abort
// QTY     | digit keys set quantity, NEXT registers the total
// CONFIRM | showing total, OK to pay, CANCEL to abort
// PAY     | accepting coins; NEXT buys when covered, CANCEL refunds
// CHANGE  | paying out change coin by coin
// VEND    | one-cycle product release
module vend_txn_controller
    import vend_pkg::*;
#(
    parameter int MAX_QTY        = 9,
    parameter int CREDIT_MAX     = 250,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       coin_ready,
    output logic [2:0] state_code,
    output logic [7:0] display_val,
    output logic [7:0] price_total,
    output logic [7:0] credit,
    output logic       coin_valid,
    output logic [3:0] coin_value,
    output logic       coin_reject,
    output logic       vend_pulse,
    output logic       busy
);

    localparam logic [3:0] MAX_QTY_L    = 4'(MAX_QTY);
    localparam logic [8:0] CREDIT_MAX_L = 9'(CREDIT_MAX);

    if (MAX_QTY < 1 || MAX_QTY > 9 || CREDIT_MAX > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("vend_txn_controller: parameter out of range");
    end

    state_e     state_q, state_d;
    logic [3:0] unit_price_q, unit_price_d;
    logic [3:0] qty_q, qty_d;
    logic [7:0] price_total_q, price_total_d;
    logic [7:0] credit_q, credit_d;
    logic       vend_pend_q, vend_pend_d;
    logic       coin_reject_q, coin_reject_d;

    logic       chg_load;
    logic [7:0] chg_amount;
    logic       chg_done;
    logic [7:0] chg_value;
    logic       is_coin;
    logic [3:0] coin_amt;
    logic [8:0] credit_sum;

`ifdef VEND_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_RELOAD = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic        timed_state;
    logic        timeout;

    always_comb begin
        timed_state = (state_q inside {ST_SELECT, ST_PRICE, ST_QTY, ST_CONFIRM, ST_PAY});
        timeout     = timed_state && !key_valid && (idle_cnt_q == 32'd0);
        if (!timed_state || key_valid || (state_d != state_q)) begin
            idle_cnt_d = TIMEOUT_RELOAD;
        end else begin
            idle_cnt_d = idle_cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt_q <= TIMEOUT_RELOAD;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    always_comb begin
        is_coin  = 1'b1;
        coin_amt = 4'd0;
        case (key_code)
            KEY_COIN1:  coin_amt = COIN_1;
            KEY_COIN5:  coin_amt = COIN_5;
            KEY_COIN10: coin_amt = COIN_10;
            default:    is_coin  = 1'b0;
        endcase
        credit_sum = {1'b0, credit_q} + {5'b0, coin_amt};
    end

    always_comb begin
        state_d       = state_q;
        unit_price_d  = unit_price_q;
        qty_d         = qty_q;
        price_total_d = price_total_q;
        credit_d      = credit_q;
        vend_pend_d   = vend_pend_q;
        coin_reject_d = 1'b0;
        chg_load      = 1'b0;
        chg_amount    = credit_q;

        case (state_q)
            ST_IDLE: begin
                if (key_valid && key_code == KEY_NEXT) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (key_valid && product_price(key_code) != 4'd0) begin
                    unit_price_d = product_price(key_code);
                    qty_d        = 4'd1;
                    state_d      = ST_PRICE;
                end
            end
            ST_PRICE: begin
                if (key_valid && key_code == KEY_OK)     state_d = ST_QTY;
                if (key_valid && key_code == KEY_CANCEL) state_d = ST_IDLE;
            end
            ST_QTY: begin
                if (key_valid && key_code >= 4'd1 && key_code <= MAX_QTY_L) begin
                    qty_d = key_code;
                end else if (key_valid && key_code == KEY_NEXT) begin
                    price_total_d = {4'b0, unit_price_q} * {4'b0, qty_q};
                    state_d       = ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                if (key_valid && key_code == KEY_OK)     state_d = ST_PAY;
                if (key_valid && key_code == KEY_CANCEL) state_d = ST_IDLE;
            end
            ST_PAY: begin
                if (key_valid && is_coin) begin
                    if (credit_sum <= CREDIT_MAX_L) credit_d = credit_sum[7:0];
                    else                            coin_reject_d = 1'b1;
                end else if (key_valid && key_code == KEY_NEXT && credit_q >= price_total_q) begin
                    chg_load    = 1'b1;
                    chg_amount  = credit_q - price_total_q;
                    credit_d    = 8'd0;
                    vend_pend_d = 1'b1;
                    state_d     = ST_CHANGE;
                end else if (key_valid && key_code == KEY_CANCEL) begin
                    chg_load    = 1'b1;
                    credit_d    = 8'd0;
                    vend_pend_d = 1'b0;
                    state_d     = ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                if (chg_done) begin
                    state_d     = vend_pend_q ? ST_VEND : ST_IDLE;
                    vend_pend_d = 1'b0;
                end
            end
            ST_VEND:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

`ifdef VEND_TIMEOUT_EN
        // A timeout behaves like CANCEL: PAY refunds, every other state aborts.
        if (timeout) begin
            if (state_q == ST_PAY) begin
                chg_load    = 1'b1;
                chg_amount  = credit_q;
                credit_d    = 8'd0;
                vend_pend_d = 1'b0;
                state_d     = ST_CHANGE;
            end else begin
                state_d = ST_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            unit_price_q  <= 4'd0;
            qty_q         <= 4'd1;
            price_total_q <= 8'd0;
            credit_q      <= 8'd0;
            vend_pend_q   <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            unit_price_q  <= unit_price_d;
            qty_q         <= qty_d;
            price_total_q <= price_total_d;
            credit_q      <= credit_d;
            vend_pend_q   <= vend_pend_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    change_dispenser u_change (
        .clk        (clk),
        .reset      (reset),
        .load       (chg_load),
        .amount     (chg_amount),
        .coin_ready (coin_ready),
        .coin_valid (coin_valid),
        .coin_value (coin_value),
        .done       (chg_done),
        .change     (chg_value)
    );

    always_comb begin
        display_val = 8'd0;
        case (state_q)
            ST_PRICE:   display_val = {4'b0, unit_price_q};
            ST_QTY:     display_val = {4'b0, qty_q};
            ST_CONFIRM: display_val = price_total_q;
            ST_PAY:     display_val = credit_q;
            ST_CHANGE:  display_val = chg_value;
            default:    display_val = 8'd0;
        endcase
    end

    assign state_code  = state_q;
    assign price_total = price_total_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign vend_pulse  = (state_q == ST_VEND);
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vend_txn_controller.sv
// Self-checking bench for vend_txn_controller: transaction-level reference
// model compared every cycle, plus literal expectations from the test plan.
module tb_vend_txn_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       coin_ready = 1'b1;
    logic [2:0] state_code;
    logic [7:0] display_val, price_total, credit;
    logic       coin_valid, coin_reject, vend_pulse, busy;
    logic [3:0] coin_value;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    vend_txn_controller dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .coin_ready(coin_ready), .state_code(state_code), .display_val(display_val),
        .price_total(price_total), .credit(credit), .coin_valid(coin_valid),
        .coin_value(coin_value), .coin_reject(coin_reject), .vend_pulse(vend_pulse),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: stage numbers follow the documented state codes.
    int m_st = 0, m_unit = 0, m_qty = 1, m_total = 0, m_credit = 0;
    int m_coins[$];
    bit m_vend = 0, m_rej = 0;
    int prices[6] = '{0, 6, 10, 5, 2, 1};
    int denoms[3] = '{10, 5, 1};

    function automatic void load_change(input int amt);
        int a;
        a = amt;
        m_coins.delete();
        foreach (denoms[i])
            while (a >= denoms[i]) begin
                m_coins.push_back(denoms[i]);
                a -= denoms[i];
            end
    endfunction

    always @(posedge clk) begin
        int k, nxt, v;
        k = int'(key_code);
        if (!reset) begin
            m_st = 0; m_unit = 0; m_qty = 1; m_total = 0; m_credit = 0;
            m_coins.delete(); m_vend = 0; m_rej = 0;
        end else begin
            nxt = m_st;
            m_rej = 0;
            case (m_st)
                0: if (key_valid && k == 15) nxt = 1;
                1: if (key_valid && k >= 1 && k <= 5) begin
                       m_unit = prices[k]; m_qty = 1; nxt = 2;
                   end
                2: if (key_valid && k == 14) nxt = 3;
                   else if (key_valid && k == 12) nxt = 0;
                3: if (key_valid && k >= 1 && k <= 9) m_qty = k;
                   else if (key_valid && k == 15) begin
                       m_total = m_unit * m_qty; nxt = 4;
                   end
                4: if (key_valid && k == 14) nxt = 5;
                   else if (key_valid && k == 12) nxt = 0;
                5: if (key_valid && (k == 8 || k == 9 || k == 10)) begin
                       v = (k == 8) ? 1 : (k == 9) ? 5 : 10;
                       if (m_credit + v <= 250) m_credit += v;
                       else m_rej = 1;
                   end else if (key_valid && k == 15 && m_credit >= m_total) begin
                       load_change(m_credit - m_total); m_credit = 0; m_vend = 1; nxt = 6;
                   end else if (key_valid && k == 12) begin
                       load_change(m_credit); m_credit = 0; m_vend = 0; nxt = 6;
                   end
                6: if (m_coins.size() == 0) begin
                       nxt = m_vend ? 7 : 0; m_vend = 0;
                   end else if (coin_ready) begin
                       void'(m_coins.pop_front());
                   end
                default: nxt = 0;
            endcase
            m_st = nxt;
        end
    end

    always @(negedge clk) begin
        int owed, exp_disp;
        if (chk_en) begin
            owed = 0;
            foreach (m_coins[i]) owed += m_coins[i];
            case (m_st)
                2: exp_disp = m_unit;
                3: exp_disp = m_qty;
                4: exp_disp = m_total;
                5: exp_disp = m_credit;
                6: exp_disp = owed;
                default: exp_disp = 0;
            endcase
            chk("state_code", state_code, m_st);
            chk("display_val", display_val, exp_disp);
            chk("price_total", price_total, m_total);
            chk("credit", credit, m_credit);
            chk("busy", busy, int'(m_st != 0));
            chk("vend_pulse", vend_pulse, int'(m_st == 7));
            chk("coin_reject", coin_reject, int'(m_rej));
            chk("coin_valid", coin_valid, int'(m_st == 6 && m_coins.size() > 0));
            if (m_st == 6 && m_coins.size() > 0) chk("coin_value", coin_value, m_coins[0]);
        end
    end

    int vend_cnt = 0;
    int dut_coins[$];
    always @(negedge clk) begin
        if (vend_pulse) vend_cnt++;
        if (reset && coin_valid && coin_ready) dut_coins.push_back(int'(coin_value));
    end

    task automatic press(input logic [3:0] k);
        @(posedge clk); #1;
        key_valid = 1'b1; key_code = k;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic buy_prefix(input logic [3:0] prod, input logic [3:0] q);
        press(4'hF); press(prod); press(4'hE); press(q); press(4'hF); press(4'hE);
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (state_code == 3'd0) seen = 1;
        end
        chk({name, "_reaches_idle"}, int'(seen), 1);
    endtask

    task automatic check_coins(input string name, input int exp[$]);
        chk({name, "_coin_count"}, dut_coins.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dut_coins.size(); i++)
            chk({name, "_coin"}, dut_coins[i], exp[i]);
        dut_coins.delete();
    endtask

    initial begin
        int v0;
        int none[$];
        int exp2[$];
        int exp4[$];
        exp2.push_back(10);
        exp4.push_back(10); exp4.push_back(5); exp4.push_back(1);

        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("reset_state", state_code, 0);
        chk("reset_credit", credit, 0);
        chk("reset_display", display_val, 0);
        chk("reset_coin_valid", coin_valid, 0);
        reset = 1'b1;

        // Exact payment: product 3 (5) x2 = 10, pay 10.
        v0 = vend_cnt;
        buy_prefix(4'd3, 4'd2);
        press(4'hA);
        @(negedge clk);
        chk("t1_price_total", price_total, 10);
        chk("t1_credit", credit, 10);
        press(4'hF);
        @(negedge clk);
        chk("t1_change_no_coin", int'(coin_valid), 0);
        wait_idle("t1", 10);
        chk("t1_vend_count", vend_cnt - v0, 1);
        check_coins("t1", none);

        // Overpay 20 for price 10: one 10 coin back.
        v0 = vend_cnt;
        buy_prefix(4'd2, 4'd1);
        press(4'hA); press(4'h9); press(4'h9);
        @(negedge clk);
        chk("t2_credit", credit, 20);
        press(4'hF);
        wait_idle("t2", 20);
        chk("t2_vend_count", vend_cnt - v0, 1);
        check_coins("t2", exp2);

        // Insufficient credit ignores NEXT.
        v0 = vend_cnt;
        buy_prefix(4'd1, 4'd1);
        press(4'h9); press(4'hF);
        @(negedge clk);
        chk("t3_still_pay", state_code, 5);
        chk("t3_credit", credit, 5);
        press(4'h8);
        @(negedge clk);
        chk("t3_credit_exact", credit, 6);
        press(4'hF);
        wait_idle("t3", 10);
        chk("t3_vend_count", vend_cnt - v0, 1);
        check_coins("t3", none);

        // Cancel with 16 while the dispenser stalls.
        v0 = vend_cnt;
        buy_prefix(4'd4, 4'd1);
        press(4'hA); press(4'h9); press(4'h8);
        @(posedge clk); #1 coin_ready = 1'b0;
        press(4'hC);
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall_value", coin_value, 10);
        end
        @(posedge clk); #1 coin_ready = 1'b1;
        wait_idle("t4", 20);
        chk("t4_vend_count", vend_cnt - v0, 0);
        check_coins("t4", exp4);

        // Credit ceiling: 248 + 5 rejected, 248 + 1 accepted.
        buy_prefix(4'd5, 4'd1);
        repeat (24) press(4'hA);
        press(4'h9); press(4'h8); press(4'h8); press(4'h8);
        @(negedge clk);
        chk("t5_credit_248", credit, 248);
        press(4'h9);
        @(negedge clk);
        chk("t5_reject", coin_reject, 1);
        chk("t5_credit_kept", credit, 248);
        press(4'h8);
        @(negedge clk);
        chk("t5_credit_249", credit, 249);
        press(4'hC);
        wait_idle("t5", 100);
        dut_coins.delete();

        // Reset in the middle of paying out 7.
        buy_prefix(4'd5, 4'd1);
        press(4'h9); press(4'h8); press(4'h8);
        @(posedge clk); #1 coin_ready = 1'b0;
        press(4'hC);
        @(negedge clk);
        chk("t6_in_change", state_code, 6);
        chk("t6_change_7", display_val, 7);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("t6_idle_after_reset", state_code, 0);
        chk("t6_coin_valid", coin_valid, 0);
        chk("t6_credit", credit, 0);
        coin_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
